conv1_layer1_dense_sched: RTL

//  Issue scheduler for the conv1 layer1 dense pipeline (feature/A-matrix BRAM -> 25-wide multiply -> 25-wise adder tree -> 16-to-1024 fanout).
//  On start, issues NUM_VEC need_data request pulses to the BRAM readers, limited by a credit count of results still in flight.

---
 rtl/conv1_layer1_dense_sched.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/conv1_layer1_dense_sched.sv
// Issue scheduler for the conv1 layer1 dense pipeline: paces BRAM read requests
// against a credit count of in-flight adder-tree results and reports completion.
module conv1_layer1_dense_sched #(
    parameter int NUM_VEC      = 1024,
    parameter int MAX_INFLIGHT = 8,
    parameter int CNT_W        = 11,
    parameter int CRD_W        = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    input  logic             res_v,
    output logic             need_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] res_cnt,
    output logic             err_ovf,
    output logic             err_tmo,
    output logic [1:0]       dbg_state
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] NUM_VEC_C = CNT_W'(NUM_VEC);
    localparam logic [CRD_W-1:0] MAX_C     = CRD_W'(MAX_INFLIGHT);
    localparam logic [TMR_W-1:0] TMO_C     = TMR_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
    logic [CRD_W-1:0] inflight_q, inflight_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_tmo_q, err_tmo_d;
    logic             issue_go;
    logic             res_ok;

    // Handshake: need_data is a one-cycle request with no back-pressure; each
    // accepted request is answered by exactly one res_v pulse some cycles later.
    assign issue_go = (state_q == S_RUN) && (issue_cnt_q < NUM_VEC_C)
                      && (inflight_q < MAX_C) && !stall;
    assign res_ok   = res_v && (inflight_q != '0);

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        res_cnt_d   = res_cnt_q;
        inflight_d  = inflight_q;
        timer_d     = timer_q;
        err_ovf_d   = err_ovf_q;
        err_tmo_d   = err_tmo_q;

        if (issue_go) begin
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
        end
        if (res_ok) begin
            res_cnt_d = res_cnt_q + CNT_W'(1);
        end else if (res_v) begin
            err_ovf_d = 1'b1;
        end

        case ({issue_go, res_ok})
            2'b10:   inflight_d = inflight_q + CRD_W'(1);
            2'b01:   inflight_d = inflight_q - CRD_W'(1);
            default: inflight_d = inflight_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RUN;
                    issue_cnt_d = '0;
                    res_cnt_d   = '0;
                    inflight_d  = '0;
                    timer_d     = '0;
                    err_ovf_d   = 1'b0;
                    err_tmo_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (issue_go && (issue_cnt_d == NUM_VEC_C)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                timer_d = res_v ? '0 : timer_q + TMR_W'(1);
                // A finished run wins over a timeout expiring on the same edge.
                if ((res_cnt_q == NUM_VEC_C) && (inflight_q == '0)) begin
                    state_d = S_DONE;
                end else if (timer_q == TMO_C) begin
                    state_d    = S_IDLE;
                    err_tmo_d  = 1'b1;
                    inflight_d = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            res_cnt_q   <= '0;
            inflight_q  <= '0;
            timer_q     <= '0;
            err_ovf_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            res_cnt_q   <= res_cnt_d;
            inflight_q  <= inflight_d;
            timer_q     <= timer_d;
            err_ovf_q   <= err_ovf_d;
            err_tmo_q   <= err_tmo_d;
        end
    end

    assign need_data = issue_go;
    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign issue_cnt = issue_cnt_q;
    assign res_cnt   = res_cnt_q;
    assign err_ovf   = err_ovf_q;
    assign err_tmo   = err_tmo_q;
    assign dbg_state = state_q;

endmodule
